pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4: number of return-stack entries, power of two, at least 2.
REQ-002 clk  input  1  clock; all logic on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 pc  input  15  current PC value from the program counter register.
REQ-005 imem_ready  input  1  instruction memory has accepted the fetch request.
REQ-006 stall  input  1  hold the current instruction in S_DECIDE.
REQ-007 halt  input  1  enter S_HALT.
REQ-008 branch_take  input  1  conditional branch taken.
REQ-009 branch_off  input  15  two's-complement offset, relative to pc+1.
REQ-010 jump  input  1  absolute jump request.
REQ-011 call  input  1  absolute jump that also saves the return address.
REQ-012 ret  input  1  return to the popped address.
REQ-013 jump_addr  input  15  target address for jump and call.
REQ-014 pc_en  output  1  load enable to the program counter register.
REQ-015 pc_next  output  15  value to load into the program counter register.
REQ-016 fetch_req  output  1  instruction fetch request.
REQ-017 stack_err  output  1  sticky flag: return-stack overflow or underflow.

Function
REQ-018 States: S_BOOT, S_FETCH, S_DECIDE, S_HALT.
REQ-019 S_BOOT:
- pc_en=0, fetch_req=0.
- Next state is always S_FETCH.
REQ-020 S_FETCH:
- fetch_req=1, pc_en=0.
- imem_ready=1 -> S_DECIDE; otherwise remain in S_FETCH.
REQ-021 S_DECIDE with stall=1:
- pc_en=0; remain in S_DECIDE.
- Redirect inputs are ignored.
REQ-022 S_DECIDE with stall=0:
- pc_en=1 for exactly one cycle.
- Next state is S_FETCH.
REQ-023 pc_next priority, highest first:
- ret -> popped address
- call -> jump_addr
- jump -> jump_addr
- branch_take -> pc+1+branch_off
- otherwise -> pc+1
REQ-024 All address arithmetic is 15-bit modulo 2^15; 0x7FFF+1 wraps to 0x0000, with no error.
REQ-025 pc_next is combinational from the current inputs; pc_en is asserted in the same cycle as the decision, so latency from decision to pc update is one clock.
REQ-026 halt=1 in any state except S_BOOT moves to S_HALT at the next edge and has priority over every other transition.
REQ-027 S_HALT: pc_en=0, fetch_req=0; only reset leaves this state.
REQ-028 call and ret asserted together: ret is performed and call is ignored; no push occurs.
REQ-029 pc_en and fetch_req are never high in the same cycle.

Reset
REQ-030 At reset:
- state=S_BOOT; pc_en=0, fetch_req=0, stack_err=0, pc_next=0.
- Stack pointer is cleared to empty.
REQ-031 Reset asserted mid-fetch or mid-stall takes precedence over all inputs, and any outstanding fetch is abandoned.

Configuration
REQ-032 Macro PC_SEQ_CALL_STACK_EN, when defined:
- call pushes pc+1, then redirects to jump_addr.
- ret pops and redirects to the popped address.
REQ-033 Push when the stack holds STACK_DEPTH entries:
- The push is dropped and the redirect still occurs.
- stack_err is set.
REQ-034 Pop when the stack is empty:
- pc_next = pc+1.
- stack_err is set.
REQ-035 stack_err stays set until reset.
REQ-036 Without the macro:
- call behaves exactly as jump, and ret behaves as pc+1.
- stack_err is tied to 0 and no stack storage is built.

Structure
REQ-037 Shared package pc_seq_pkg contains:
- the state enumeration
- the PC width constant (15)
- the reset vector constant (0x0000)
REQ-038 Sub-module ret_stack holds the LIFO storage, pointer, and full/empty flags; it is instantiated only under PC_SEQ_CALL_STACK_EN.

Verification
REQ-039 Boot sequence: deassert reset, pc=0x0000, imem_ready=1 with no delay.
- S_BOOT, then fetch_req in S_FETCH, then pc_en=1 with pc_next=0x0001 in S_DECIDE.
REQ-040 Branch and wrap:
- pc=0x0010, branch_take=1, branch_off=0x7FFE (-2) -> pc_next=0x000F.
- pc=0x7FFF, no redirect -> pc_next=0x0000.
REQ-041 Wait states: imem_ready held low for 3 cycles, then stall held for 2 cycles.
- fetch_req stays high for 4 cycles.
- pc_en goes high only in the cycle after stall drops.
REQ-042 Call/return (macro defined):
- call at pc=0x0100 with jump_addr=0x0200 -> pc_next=0x0200.
- A later ret -> pc_next=0x0101.
- A 5th nested call with STACK_DEPTH=4 -> stack_err=1.
REQ-043 Simultaneous and empty-stack cases: call and ret asserted together on an empty stack.
- pc_next=pc+1 and stack_err=1.
- Without the macro, the same stimulus gives pc_next=jump_addr and stack_err=0.
REQ-044 Halt and reset: halt asserted in S_FETCH.
- pc_en=0 and fetch_req=0 for all following cycles.
- A subsequent reset returns to S_BOOT.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared state encoding, PC width and reset vector for the PC sequencer slice.
package pc_seq_pkg;

  localparam int PC_W = 15;
  localparam logic [PC_W-1:0] RESET_VEC = 15'h0000;

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECIDE = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // Address arithmetic wraps modulo 2^PC_W by construction.
  function automatic logic [PC_W-1:0] pcAdd(input logic [PC_W-1:0] a,
                                            input logic [PC_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// LIFO of return addresses with occupancy count and full/empty flags.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] data_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_CNT  = (PW+1)'(1);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PW:0]     count_q, count_d;
  logic [PW-1:0]   topIdx;
  logic            doPush, doPop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign topIdx  = PW'(count_q - ONE_CNT);
  assign data_o  = mem_q[topIdx];

  always_comb begin
    count_d = count_q;
    if (doPush) begin
      count_d = count_q + ONE_CNT;
    end else if (doPop) begin
      count_d = count_q - ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[count_q[PW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decide sequencer producing the next PC; return stack built only when
// PC_SEQ_CALL_STACK_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] pc,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            halt,
  input  logic            branch_take,
  input  logic [PC_W-1:0] branch_off,
  input  logic            jump,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jump_addr,
  output logic            pc_en,
  output logic [PC_W-1:0] pc_next,
  output logic            fetch_req,
  output logic            stack_err
);

  state_t          state_q, state_d;
  logic            pcEnRaw, fetchReqRaw, decideGo;
  logic [PC_W-1:0] pcPlus1, branchTarget, nextPc;
  logic            retTaken, popValid;
  logic [PC_W-1:0] stackTop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pcEnRaw     = 1'b0;
    fetchReqRaw = 1'b0;
    case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH: begin
        fetchReqRaw = 1'b1;
        if (imem_ready) state_d = S_DECIDE;
      end
      S_DECIDE: begin
        if (!stall) begin
          pcEnRaw = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_BOOT;
    endcase
    // Halt overrides everything after boot and abandons any pending update.
    if (halt && state_q != S_BOOT) begin
      state_d = S_HALT;
      pcEnRaw = 1'b0;
    end
  end

  assign decideGo     = pcEnRaw & ~reset;
  assign pcPlus1      = pcAdd(pc, 15'd1);
  assign branchTarget = pcAdd(pcPlus1, branch_off);

`ifdef PC_SEQ_CALL_STACK_EN
  logic pushReq, popReq, stackFull, stackEmpty;
  logic stackErr_q, stackErr_d;

  // A simultaneous call is dropped in favour of the return.
  assign retTaken = ret;
  assign popValid = ~stackEmpty;
  assign pushReq  = decideGo & call & ~ret;
  assign popReq   = decideGo & ret;

  ret_stack #(
    .DEPTH(STACK_DEPTH)
  ) uRetStack (
    .clk    (clk),
    .reset  (reset),
    .push_i (pushReq),
    .pop_i  (popReq),
    .data_i (pcPlus1),
    .data_o (stackTop),
    .full_o (stackFull),
    .empty_o(stackEmpty)
  );

  always_comb begin
    stackErr_d = stackErr_q | (pushReq & stackFull) | (popReq & stackEmpty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stackErr_q <= 1'b0;
    end else begin
      stackErr_q <= stackErr_d;
    end
  end

  assign stack_err = stackErr_q;
`else
  logic        unusedRet;
  logic [31:0] unusedDepth;

  assign retTaken    = 1'b0;
  assign popValid    = 1'b0;
  assign stackTop    = RESET_VEC;
  assign stack_err   = 1'b0;
  assign unusedRet   = ret;
  assign unusedDepth = STACK_DEPTH;
`endif

  always_comb begin
    nextPc = pcPlus1;
    if (retTaken) begin
      nextPc = popValid ? stackTop : pcPlus1;
    end else if (call || jump) begin
      nextPc = jump_addr;
    end else if (branch_take) begin
      nextPc = branchTarget;
    end
  end

  assign pc_next   = reset ? RESET_VEC : nextPc;
  assign pc_en     = decideGo;
  assign fetch_req = fetchReqRaw & ~reset;

endmodule
